// File: rtl/axil2lb_pkg.sv
// axil2lb_pkg: shared definitions for the AXI4-Lite to Local Bus bridge.
//   RESP_OKAY - AXI response code; the bridge only ever returns OKAY.
//   w_state_e - write-channel FSM states (kept in the top module).
//   r_state_e - read-channel FSM states (kept in axil2lb_rch).
package axil2lb_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_LB,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LB,
    R_RESP
  } r_state_e;

endpackage

// File: rtl/axil2lb_rch.sv
// axil2lb_rch: read channel of the AXI4-Lite to Local Bus bridge.
//   clk, rst                         - clock, asynchronous active-high reset
//   axil_araddr/arvalid/arready      - AXI read address channel (slave side)
//   axil_rdata/rresp/rvalid/rready   - AXI read data channel (slave side)
//   lb_raddr/lb_ren                  - Local Bus read request (held until lb_rvalid)
//   lb_rdata/lb_rvalid               - Local Bus read return
module axil2lb_rch
  import axil2lb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] axil_araddr,
  input  logic              axil_arvalid,
  output logic              axil_arready,
  output logic [DATA_W-1:0] axil_rdata,
  output logic [1:0]        axil_rresp,
  output logic              axil_rvalid,
  input  logic              axil_rready,
  output logic [ADDR_W-1:0] lb_raddr,
  output logic              lb_ren,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_rvalid
);

  r_state_e state;

  // Gated with rst so arready is low throughout reset but high on the very
  // first cycle after it falls, without waiting for a clock edge.
  assign axil_arready = (state == R_IDLE) && !rst;
  assign axil_rresp   = RESP_OKAY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= R_IDLE;
      lb_raddr    <= '0;
      lb_ren      <= 1'b0;
      axil_rdata  <= '0;
      axil_rvalid <= 1'b0;
    end else begin
      unique case (state)
        R_IDLE: begin
          if (axil_arvalid) begin
            lb_raddr <= axil_araddr;
            lb_ren   <= 1'b1;
            state    <= R_LB;
          end
        end
        R_LB: begin
          if (lb_rvalid) begin
            axil_rdata  <= lb_rdata;
            lb_ren      <= 1'b0;
            axil_rvalid <= 1'b1;
            state       <= R_RESP;
          end
        end
        R_RESP: begin
          if (axil_rready) begin
            axil_rvalid <= 1'b0;
            state       <= R_IDLE;
          end
        end
        default: begin
          state       <= R_IDLE;
          lb_ren      <= 1'b0;
          axil_rvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/axil2lb.sv
// axil2lb: AXI4-Lite slave to simple Local Bus master bridge.
//   clk, rst                            - clock, asynchronous active-high reset
//   axil_aw*, axil_w*, axil_b*          - AXI write channels (slave side)
//   axil_ar*, axil_r*                   - AXI read channels (slave side)
//   lb_waddr/wdata/wstrb/wen, lb_wready - Local Bus write (wen held until wready)
//   lb_raddr/ren, lb_rdata/rvalid       - Local Bus read (ren held until rvalid)
// Write and read paths are independent; no ordering between them is implied.
module axil2lb
  import axil2lb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] axil_awaddr,
  input  logic              axil_awvalid,
  output logic              axil_awready,
  input  logic [DATA_W-1:0] axil_wdata,
  input  logic [STRB_W-1:0] axil_wstrb,
  input  logic              axil_wvalid,
  output logic              axil_wready,
  output logic [1:0]        axil_bresp,
  output logic              axil_bvalid,
  input  logic              axil_bready,
  input  logic [ADDR_W-1:0] axil_araddr,
  input  logic              axil_arvalid,
  output logic              axil_arready,
  output logic [DATA_W-1:0] axil_rdata,
  output logic [1:0]        axil_rresp,
  output logic              axil_rvalid,
  input  logic              axil_rready,
  output logic [ADDR_W-1:0] lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic [STRB_W-1:0] lb_wstrb,
  output logic              lb_wen,
  input  logic              lb_wready,
  output logic [ADDR_W-1:0] lb_raddr,
  output logic              lb_ren,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_rvalid
);

  w_state_e w_state;
  logic     aw_held;
  logic     w_held;
  logic     aw_hs;
  logic     w_hs;

  // Each channel stays ready in W_IDLE until its own beat has been captured,
  // so AW and W may arrive in either order or together.
  assign axil_awready = (w_state == W_IDLE) && !aw_held && !rst;
  assign axil_wready  = (w_state == W_IDLE) && !w_held && !rst;
  assign axil_bresp   = RESP_OKAY;

  assign aw_hs = axil_awvalid && axil_awready;
  assign w_hs  = axil_wvalid && axil_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state     <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      lb_waddr    <= '0;
      lb_wdata    <= '0;
      lb_wstrb    <= '0;
      lb_wen      <= 1'b0;
      axil_bvalid <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            lb_waddr <= axil_awaddr;
            aw_held  <= 1'b1;
          end
          if (w_hs) begin
            lb_wdata <= axil_wdata;
            lb_wstrb <= axil_wstrb;
            w_held   <= 1'b1;
          end
          // Leave on the edge that completes the pair, not one cycle later.
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            lb_wen  <= 1'b1;
            w_state <= W_LB;
          end
        end
        W_LB: begin
          if (lb_wready) begin
            lb_wen      <= 1'b0;
            axil_bvalid <= 1'b1;
            w_state     <= W_RESP;
          end
        end
        W_RESP: begin
          if (axil_bready) begin
            axil_bvalid <= 1'b0;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            w_state     <= W_IDLE;
          end
        end
        default: begin
          w_state     <= W_IDLE;
          aw_held     <= 1'b0;
          w_held      <= 1'b0;
          lb_wen      <= 1'b0;
          axil_bvalid <= 1'b0;
        end
      endcase
    end
  end

  axil2lb_rch #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rch (
    .clk          (clk),
    .rst          (rst),
    .axil_araddr  (axil_araddr),
    .axil_arvalid (axil_arvalid),
    .axil_arready (axil_arready),
    .axil_rdata   (axil_rdata),
    .axil_rresp   (axil_rresp),
    .axil_rvalid  (axil_rvalid),
    .axil_rready  (axil_rready),
    .lb_raddr     (lb_raddr),
    .lb_ren       (lb_ren),
    .lb_rdata     (lb_rdata),
    .lb_rvalid    (lb_rvalid)
  );

endmodule

// File: tb/tb_axil2lb.sv
// tb_axil2lb: directed self-checking bench for axil2lb. A tiny Local Bus
// memory answers writes; address 0x8 always reads back 0x00ffff00.
module tb_axil2lb;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] axil_awaddr;
  logic              axil_awvalid;
  logic              axil_awready;
  logic [DATA_W-1:0] axil_wdata;
  logic [STRB_W-1:0] axil_wstrb;
  logic              axil_wvalid;
  logic              axil_wready;
  logic [1:0]        axil_bresp;
  logic              axil_bvalid;
  logic              axil_bready;
  logic [ADDR_W-1:0] axil_araddr;
  logic              axil_arvalid;
  logic              axil_arready;
  logic [DATA_W-1:0] axil_rdata;
  logic [1:0]        axil_rresp;
  logic              axil_rvalid;
  logic              axil_rready;
  logic [ADDR_W-1:0] lb_waddr;
  logic [DATA_W-1:0] lb_wdata;
  logic [STRB_W-1:0] lb_wstrb;
  logic              lb_wen;
  logic              lb_wready;
  logic [ADDR_W-1:0] lb_raddr;
  logic              lb_ren;
  logic [DATA_W-1:0] lb_rdata;
  logic              lb_rvalid;

  int errors = 0;
  int checks = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  int base;

  logic [DATA_W-1:0] mem [16];

  always #5 clk = ~clk;

  axil2lb #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STRB_W(STRB_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .axil_awaddr  (axil_awaddr),
    .axil_awvalid (axil_awvalid),
    .axil_awready (axil_awready),
    .axil_wdata   (axil_wdata),
    .axil_wstrb   (axil_wstrb),
    .axil_wvalid  (axil_wvalid),
    .axil_wready  (axil_wready),
    .axil_bresp   (axil_bresp),
    .axil_bvalid  (axil_bvalid),
    .axil_bready  (axil_bready),
    .axil_araddr  (axil_araddr),
    .axil_arvalid (axil_arvalid),
    .axil_arready (axil_arready),
    .axil_rdata   (axil_rdata),
    .axil_rresp   (axil_rresp),
    .axil_rvalid  (axil_rvalid),
    .axil_rready  (axil_rready),
    .lb_waddr     (lb_waddr),
    .lb_wdata     (lb_wdata),
    .lb_wstrb     (lb_wstrb),
    .lb_wen       (lb_wen),
    .lb_wready    (lb_wready),
    .lb_raddr     (lb_raddr),
    .lb_ren       (lb_ren),
    .lb_rdata     (lb_rdata),
    .lb_rvalid    (lb_rvalid)
  );

  // Local Bus slave model: byte-strobed memory, plus strobe counters.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (lb_wen && lb_wready) begin
        for (int b = 0; b < STRB_W; b++)
          if (lb_wstrb[b]) mem[lb_waddr[5:2]][8*b +: 8] <= lb_wdata[8*b +: 8];
        wen_cnt <= wen_cnt + 1;
      end
      if (lb_ren) ren_cnt <= ren_cnt + 1;
    end
  end

  assign lb_rdata = (lb_raddr == 16'h0008) ? 32'h00ff_ff00 : mem[lb_raddr[5:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    axil_awaddr = '0; axil_awvalid = 1'b0;
    axil_wdata = '0; axil_wstrb = '0; axil_wvalid = 1'b0; axil_bready = 1'b0;
    axil_araddr = '0; axil_arvalid = 1'b0; axil_rready = 1'b0;
    lb_wready = 1'b1; lb_rvalid = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_awready", {31'd0, axil_awready}, 32'd0);
    chk("rst_wready", {31'd0, axil_wready}, 32'd0);
    chk("rst_arready", {31'd0, axil_arready}, 32'd0);
    chk("rst_bvalid", {31'd0, axil_bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, axil_rvalid}, 32'd0);
    chk("rst_wen_ren", {30'd0, lb_wen, lb_ren}, 32'd0);
    chk("rst_rdata", axil_rdata, 32'd0);
    chk("rst_waddr", {16'd0, lb_waddr}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_readies", {29'd0, axil_awready, axil_wready, axil_arready}, 32'd7);

    // AW three cycles before W
    axil_awvalid = 1'b1; axil_awaddr = 16'h0000;
    tick();
    axil_awvalid = 1'b0;
    chk("aw_first_awready", {31'd0, axil_awready}, 32'd0);
    chk("aw_first_wready", {31'd0, axil_wready}, 32'd1);
    tick(); tick();
    axil_wvalid = 1'b1; axil_wdata = 32'hdead_beef; axil_wstrb = 4'hf;
    tick();
    axil_wvalid = 1'b0;
    chk("w1_wen", {31'd0, lb_wen}, 32'd1);
    chk("w1_waddr", {16'd0, lb_waddr}, 32'h0);
    chk("w1_wdata", lb_wdata, 32'hdead_beef);
    chk("w1_readies_low", {30'd0, axil_awready, axil_wready}, 32'd0);
    chk("w1_no_bvalid_yet", {31'd0, axil_bvalid}, 32'd0);
    tick();
    chk("w1_wen_drop", {31'd0, lb_wen}, 32'd0);
    chk("w1_bvalid", {31'd0, axil_bvalid}, 32'd1);
    chk("w1_bresp", {30'd0, axil_bresp}, 32'd0);
    axil_bready = 1'b1;
    tick();
    axil_bready = 1'b0;
    chk("w1_bvalid_clr", {31'd0, axil_bvalid}, 32'd0);
    chk("w1_awready_back", {31'd0, axil_awready}, 32'd1);
    chk("w1_wen_count", wen_cnt, 32'd1);

    // Read back 0x0 with immediate lb_rvalid
    lb_rvalid = 1'b1; axil_arvalid = 1'b1; axil_araddr = 16'h0000;
    tick();
    axil_arvalid = 1'b0;
    chk("r1_ren", {31'd0, lb_ren}, 32'd1);
    chk("r1_raddr", {16'd0, lb_raddr}, 32'h0);
    chk("r1_arready_low", {31'd0, axil_arready}, 32'd0);
    tick();
    chk("r1_rvalid", {31'd0, axil_rvalid}, 32'd1);
    chk("r1_rdata", axil_rdata, 32'hdead_beef);
    chk("r1_ren_drop", {31'd0, lb_ren}, 32'd0);
    axil_rready = 1'b1;
    tick();
    axil_rready = 1'b0; lb_rvalid = 1'b0;
    chk("r1_rvalid_clr", {31'd0, axil_rvalid}, 32'd0);

    // W before AW
    axil_wvalid = 1'b1; axil_wdata = 32'h6677_8899; axil_wstrb = 4'h2;
    tick();
    axil_wvalid = 1'b0;
    chk("w2_wready_low", {31'd0, axil_wready}, 32'd0);
    chk("w2_awready_high", {31'd0, axil_awready}, 32'd1);
    chk("w2_no_wen", {31'd0, lb_wen}, 32'd0);
    axil_awvalid = 1'b1; axil_awaddr = 16'h0004;
    tick();
    axil_awvalid = 1'b0;
    chk("w2_wen", {31'd0, lb_wen}, 32'd1);
    chk("w2_waddr", {16'd0, lb_waddr}, 32'h4);
    chk("w2_wstrb", {28'd0, lb_wstrb}, 32'h2);
    chk("w2_wdata", lb_wdata, 32'h6677_8899);
    tick();
    chk("w2_bvalid", {31'd0, axil_bvalid}, 32'd1);
    axil_bready = 1'b1;
    tick();
    axil_bready = 1'b0;
    chk("w2_wen_count", wen_cnt, 32'd2);

    // AW and W together
    axil_awvalid = 1'b1; axil_awaddr = 16'h0004;
    axil_wvalid = 1'b1; axil_wdata = 32'h6677_8899; axil_wstrb = 4'h2;
    tick();
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    chk("w3_wen", {31'd0, lb_wen}, 32'd1);
    chk("w3_wstrb", {28'd0, lb_wstrb}, 32'h2);
    tick();
    chk("w3_bvalid", {31'd0, axil_bvalid}, 32'd1);
    chk("w3_wen_drop", {31'd0, lb_wen}, 32'd0);
    axil_bready = 1'b1;
    tick();
    axil_bready = 1'b0;
    chk("w3_wen_count", wen_cnt, 32'd3);

    // Read with lb_rvalid delayed and rready held low
    base = ren_cnt;
    axil_arvalid = 1'b1; axil_araddr = 16'h0008;
    tick();
    axil_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("r2_ren_wait", {31'd0, lb_ren}, 32'd1);
      chk("r2_arready_wait", {31'd0, axil_arready}, 32'd0);
      chk("r2_raddr_stable", {16'd0, lb_raddr}, 32'h8);
      tick();
    end
    lb_rvalid = 1'b1;
    chk("r2_ren_last", {31'd0, lb_ren}, 32'd1);
    tick();
    lb_rvalid = 1'b0;
    chk("r2_ren_cycles", ren_cnt - base, 32'd5);
    for (int i = 0; i < 3; i++) begin
      chk("r2_rvalid_hold", {31'd0, axil_rvalid}, 32'd1);
      chk("r2_rdata_hold", axil_rdata, 32'h00ff_ff00);
      chk("r2_arready_hold", {31'd0, axil_arready}, 32'd0);
      tick();
    end
    axil_rready = 1'b1;
    chk("r2_rdata_final", axil_rdata, 32'h00ff_ff00);
    chk("r2_rresp", {30'd0, axil_rresp}, 32'd0);
    tick();
    axil_rready = 1'b0;
    chk("r2_rvalid_clr", {31'd0, axil_rvalid}, 32'd0);
    chk("r2_arready_back", {31'd0, axil_arready}, 32'd1);

    // Concurrent write to 0x10 and read of 0x0
    lb_rvalid = 1'b1;
    axil_awvalid = 1'b1; axil_awaddr = 16'h0010;
    axil_wvalid = 1'b1; axil_wdata = 32'h1234_5678; axil_wstrb = 4'hf;
    axil_arvalid = 1'b1; axil_araddr = 16'h0000;
    tick();
    axil_awvalid = 1'b0; axil_wvalid = 1'b0; axil_arvalid = 1'b0;
    chk("c_wen_ren", {30'd0, lb_wen, lb_ren}, 32'd3);
    tick();
    chk("c_bvalid_rvalid", {30'd0, axil_bvalid, axil_rvalid}, 32'd3);
    chk("c_resps", {28'd0, axil_bresp, axil_rresp}, 32'd0);
    chk("c_rdata", axil_rdata, 32'hdead_beef);
    axil_bready = 1'b1; axil_rready = 1'b1;
    tick();
    axil_bready = 1'b0; axil_rready = 1'b0; lb_rvalid = 1'b0;
    chk("c_wen_count", wen_cnt, 32'd4);

    // Reset during W_LB with lb_wready low
    lb_wready = 1'b0;
    axil_awvalid = 1'b1; axil_awaddr = 16'h0000;
    axil_wvalid = 1'b1; axil_wdata = 32'hcafe_f00d; axil_wstrb = 4'hf;
    tick();
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    chk("rw_wen", {31'd0, lb_wen}, 32'd1);
    tick();
    chk("rw_wen_stall", {31'd0, lb_wen}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rw_wen_async_drop", {31'd0, lb_wen}, 32'd0);
    lb_wready = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("rw_no_bvalid", {31'd0, axil_bvalid}, 32'd0);
    chk("rw_no_wen", {31'd0, lb_wen}, 32'd0);
    chk("rw_readies", {30'd0, axil_awready, axil_wready}, 32'd3);
    base = wen_cnt;
    axil_awvalid = 1'b1; axil_awaddr = 16'h0000;
    axil_wvalid = 1'b1; axil_wdata = 32'h0bad_f00d; axil_wstrb = 4'hf;
    tick();
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    chk("rw2_wen", {31'd0, lb_wen}, 32'd1);
    tick();
    chk("rw2_bvalid", {31'd0, axil_bvalid}, 32'd1);
    axil_bready = 1'b1;
    tick();
    axil_bready = 1'b0;
    chk("rw2_wen_count", wen_cnt - base, 32'd1);
    lb_rvalid = 1'b1; axil_arvalid = 1'b1; axil_araddr = 16'h0000;
    tick();
    axil_arvalid = 1'b0;
    tick();
    chk("rw2_readback", axil_rdata, 32'h0bad_f00d);
    axil_rready = 1'b1;
    tick();
    axil_rready = 1'b0; lb_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
